muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the execute stage, beside the combinational ALU.
- Takes the same rs1/rs2 operands the ALU takes, and its result feeds the same execute result mux.
- Multi-cycle: it stalls the pipeline through a valid/ready handshake while it iterates.
- Supports one operation in flight; a flush cancels it.

---
 rtl/rv_pkg.sv | 28 ++
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_iter.sv | 37 +++
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_muldiv_unit.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the execute-stage multiply/divide unit:
// operation codes, FSM state encoding and the architectural word width.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MULDIV_OP_MUL    = 3'd0;
  localparam logic [2:0] MULDIV_OP_MULH   = 3'd1;
  localparam logic [2:0] MULDIV_OP_MULHSU = 3'd2;
  localparam logic [2:0] MULDIV_OP_MULHU  = 3'd3;
  localparam logic [2:0] MULDIV_OP_DIV    = 3'd4;
  localparam logic [2:0] MULDIV_OP_DIVU   = 3'd5;
  localparam logic [2:0] MULDIV_OP_REM    = 3'd6;
  localparam logic [2:0] MULDIV_OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } muldiv_state_t;

  // Every divide/remainder opcode has bit 2 set.
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_unit_if;
  import rv_pkg::*;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output flush, in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  flush, in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/muldiv_iter.sv
// One combinational iteration step: a shift-add multiply step or a
// restoring-divide step on the {hi, lo} working pair.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff_lo;
  logic            ge;

  always_comb begin
    // Multiply: lo holds the remaining multiplier bits, product shifts right into it.
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    // Divide: the partial remainder is always below the divisor, so 32 bits of
    // hi suffice and the 33-bit shifted value carries the compare.
    shifted = {hi, lo[XLEN-1]};
    ge      = (shifted >= {1'b0, operand});
    diff_lo = shifted[XLEN-1:0] - operand;

    if (is_div) begin
      hi_next = ge ? diff_lo : shifted[XLEN-1:0];
      lo_next = {lo[XLEN-2:0], ge};
    end else begin
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitude datapath, 32 iterations,
// one fix-up cycle for sign, word select and special-case overrides.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);
  import rv_pkg::*;

  muldiv_state_t    state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       op_reg;
  logic [XLEN-1:0]  hi_reg, lo_reg, operand_reg, a_reg, result_reg;
  logic             neg_res_reg, neg_rem_reg, div_zero_reg, ovf_reg;

  logic             accept, step, fix;
  logic [XLEN-1:0]  hi_step, lo_step;

  logic             in_is_div, a_signed, b_signed, a_neg, b_neg, in_ovf;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic [2*XLEN-1:0] product, product_fixed;
  logic [XLEN-1:0]  quotient_fixed, remainder_fixed, fix_value;

  always_comb begin
    in_is_div = op_is_div(bus.op);
    a_signed  = (bus.op == MULDIV_OP_MULH) || (bus.op == MULDIV_OP_MULHSU) ||
                (bus.op == MULDIV_OP_DIV)  || (bus.op == MULDIV_OP_REM);
    b_signed  = (bus.op == MULDIV_OP_MULH) || (bus.op == MULDIV_OP_DIV) ||
                (bus.op == MULDIV_OP_REM);
    a_neg     = a_signed & bus.a[XLEN-1];
    b_neg     = b_signed & bus.b[XLEN-1];
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;
    in_ovf    = ((bus.op == MULDIV_OP_DIV) || (bus.op == MULDIV_OP_REM)) &&
                (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= MD_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    step       = 1'b0;
    fix        = 1'b0;
    case (state_reg)
      MD_IDLE: begin
        if (!bus.flush && bus.in_valid) begin
          accept     = 1'b1;
          state_next = MD_CALC;
        end
      end
      MD_CALC: begin
        if (bus.flush) begin
          state_next = MD_IDLE;
        end else begin
          step = 1'b1;
          if (cnt_reg == {CNT_W{1'b1}}) state_next = MD_FIX;
        end
      end
      MD_FIX: begin
        if (bus.flush) begin
          state_next = MD_IDLE;
        end else begin
          fix        = 1'b1;
          state_next = MD_DONE;
        end
      end
      default: begin
        if (bus.flush || bus.out_ready) state_next = MD_IDLE;
      end
    endcase
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .is_div  (op_is_div(op_reg)),
    .hi      (hi_reg),
    .lo      (lo_reg),
    .operand (operand_reg),
    .hi_next (hi_step),
    .lo_next (lo_step)
  );

  always_comb begin
    product         = {hi_reg, lo_reg};
    product_fixed   = neg_res_reg ? -product : product;
    quotient_fixed  = neg_res_reg ? -lo_reg : lo_reg;
    remainder_fixed = neg_rem_reg ? -hi_reg : hi_reg;
    fix_value       = '0;
    case (op_reg)
      MULDIV_OP_MUL:
        fix_value = product_fixed[XLEN-1:0];
      MULDIV_OP_MULH, MULDIV_OP_MULHSU, MULDIV_OP_MULHU:
        fix_value = product_fixed[2*XLEN-1:XLEN];
      MULDIV_OP_DIV, MULDIV_OP_DIVU:
        fix_value = div_zero_reg ? '1 :
                    ovf_reg      ? {1'b1, {(XLEN-1){1'b0}}} : quotient_fixed;
      default:
        fix_value = div_zero_reg ? a_reg :
                    ovf_reg      ? '0 : remainder_fixed;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg      <= '0;
      op_reg       <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      operand_reg  <= '0;
      a_reg        <= '0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
      ovf_reg      <= 1'b0;
      result_reg   <= '0;
    end else begin
      if (accept) begin
        cnt_reg      <= '0;
        op_reg       <= bus.op;
        hi_reg       <= '0;
        lo_reg       <= in_is_div ? a_mag : b_mag;
        operand_reg  <= in_is_div ? b_mag : a_mag;
        a_reg        <= bus.a;
        neg_res_reg  <= a_neg ^ b_neg;
        neg_rem_reg  <= a_neg;
        div_zero_reg <= (bus.b == '0);
        ovf_reg      <= in_ovf;
      end
      if (step) begin
        hi_reg  <= hi_step;
        lo_reg  <= lo_step;
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      if (fix) result_reg <= fix_value;
    end
  end

  assign bus.in_ready  = (state_reg == MD_IDLE);
  assign bus.out_valid = (state_reg == MD_DONE);
  assign bus.result    = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  import rv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  muldiv_unit_if bus();

  muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, pu;
    int              ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      MULDIV_OP_MUL:    begin p = sa * sb; return p[31:0]; end
      MULDIV_OP_MULH:   begin p = sa * sb; return p[63:32]; end
      MULDIV_OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      MULDIV_OP_MULHU:  begin pu = ua * ub; return pu[63:32]; end
      MULDIV_OP_DIV: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ia / ib;
      end
      MULDIV_OP_DIVU: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        return a / b;
      end
      MULDIV_OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return ia % ib;
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at the negedge after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
  endtask

  // Counts edges from the accept edge until out_valid, bounded.
  task automatic wait_done(input string tag, input logic [31:0] exp);
    int   cycles   = 0;
    logic busy_low = 1'b1;
    while (!bus.out_valid && cycles < 40) begin
      if (bus.in_ready) busy_low = 1'b0;
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    check32({tag, " latency"}, 32'(cycles), 32'd33);
    check1({tag, " in_ready low while busy"}, busy_low, 1'b1);
    check32({tag, " result"}, bus.result, exp);
    $display("op=%0d result=0x%08h expected=0x%08h cycles=%0d [%s]",
             bus.op, bus.result, exp, cycles, tag);
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check1("pop out_valid", bus.out_valid, 1'b0);
    check1("pop in_ready", bus.in_ready, 1'b1);
  endtask

  task automatic run_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
    issue(op, a, b);
    wait_done(tag, exp);
    pop();
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    logic        saw_valid;

    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    bus.out_ready = 1'b0;
    #12;
    check1("reset in_ready", bus.in_ready, 1'b1);
    check1("reset out_valid", bus.out_valid, 1'b0);
    check32("reset result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_exp(MULDIV_OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, "mul 7*-3");
    run_exp(MULDIV_OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh");
    run_exp(MULDIV_OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
    run_exp(MULDIV_OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
    run_exp(MULDIV_OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div -7/2");
    run_exp(MULDIV_OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem -7/2");
    run_exp(MULDIV_OP_DIVU,   32'd100,      32'd7,        32'd14,       "divu 100/7");
    run_exp(MULDIV_OP_REMU,   32'd100,      32'd7,        32'd2,        "remu 100/7");
    run_exp(MULDIV_OP_DIV,    32'h12345678, 32'd0,        32'hFFFFFFFF, "div by zero");
    run_exp(MULDIV_OP_REM,    32'h12345678, 32'd0,        32'h12345678, "rem by zero");
    run_exp(MULDIV_OP_DIVU,   32'h12345678, 32'd0,        32'hFFFFFFFF, "divu by zero");
    run_exp(MULDIV_OP_REMU,   32'h12345678, 32'd0,        32'h12345678, "remu by zero");
    run_exp(MULDIV_OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div overflow");
    run_exp(MULDIV_OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem overflow");

    // Back-pressure: result held, then a new request overlapping the pop is deferred.
    issue(MULDIV_OP_MUL, 32'd7, 32'hFFFFFFFD);
    wait_done("hold mul", 32'hFFFFFFEB);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check32("hold result", bus.result, 32'hFFFFFFEB);
      check1("hold out_valid", bus.out_valid, 1'b1);
      check1("hold in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op        = MULDIV_OP_DIVU;
    bus.a         = 32'd100;
    bus.b         = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check1("pop+req in_ready", bus.in_ready, 1'b1);
    check1("pop+req out_valid", bus.out_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_done("divu after hold", 32'd14);
    pop();

    // Flush at count=10 leaves the previous result in place.
    run_exp(MULDIV_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "pre-flush");
    issue(MULDIV_OP_DIVU, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    check1("flush in_ready", bus.in_ready, 1'b1);
    check1("flush out_valid", bus.out_valid, 1'b0);
    check32("flush result kept", bus.result, 32'hFFFFFFFE);
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check1("flush no out_valid", saw_valid, 1'b0);

    // Flush in IDLE wins over in_valid.
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.op       = MULDIV_OP_MUL;
    @(posedge clk);
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check1("idle flush ignores req", bus.in_ready, 1'b1);

    // Asynchronous reset mid-CALC.
    issue(MULDIV_OP_MUL, 32'd3, 32'd5);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check1("async rst in_ready", bus.in_ready, 1'b1);
    check1("async rst out_valid", bus.out_valid, 1'b0);
    check32("async rst result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_exp(MULDIV_OP_MUL, 32'd3, 32'd5, 32'd15, "after rst");

    for (int n = 0; n < 40; n++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = pick_operand();
      r_b  = pick_operand();
      run_exp(r_op, r_a, r_b, model(r_op, r_a, r_b), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
